// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the add/sub result path.
package addsub_pkg;

    localparam int DEFAULT_DEPTH     = 4;
    localparam int DEFAULT_DATAWIDTH = 8;

    // Result entry at the default adder width; modules with other widths
    // declare the same shape locally.
    typedef struct packed {
        logic                         carry;
        logic [DEFAULT_DATAWIDTH-1:0] data;
    } addsub_result_t;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read and wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    // Pop on empty is ignored; a push into a full FIFO only lands if the
    // head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == DEPTH_W);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are meaningless until pointed at, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/addsub_result_buffer.sv
// Credit-managed result buffer behind the valid-only add/sub pipeline.
module addsub_result_buffer
    import addsub_pkg::*;
#(
    parameter int DATAWIDTH   = 8,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int INSTANCE_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_fire,
    output logic                      issue_ready,
    input  logic                      res_valid,
    input  logic [DATAWIDTH-1:0]      res_data,
    input  logic                      res_carry,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATAWIDTH-1:0]      m_data,
    output logic                      m_carry,
    output logic [cnt_w(DEPTH)-1:0]   occupancy,
    output logic [cnt_w(DEPTH)-1:0]   inflight,
    output logic                      err
);

    localparam int          CW      = cnt_w(DEPTH);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    typedef struct packed {
        logic                 carry;
        logic [DATAWIDTH-1:0] data;
    } entry_t;

    entry_t      wr_entry;
    entry_t      rd_entry;
    logic        full;
    logic        empty;
    logic        issue_ok;
    logic        ret_ok;
    logic        drop;
    logic        bad_issue;
    logic        orphan;
    logic [CW:0] credit_sum;

    assign wr_entry = '{carry: res_carry, data: res_data};

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (res_valid),
        .wr_data (wr_entry),
        .pop     (m_ready),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (occupancy)
    );

    assign m_valid = ~empty;
    assign m_data  = rd_entry.data;
    assign m_carry = rd_entry.carry;

    // Credits come only from registered occupancy/inflight, so issue_ready
    // never depends combinationally on this cycle's inputs.
    assign credit_sum  = {1'b0, occupancy} + {1'b0, inflight};
    assign issue_ready = (credit_sum < DEPTH_W);

    assign issue_ok  = issue_fire & issue_ready;
    assign ret_ok    = res_valid & (inflight != '0);
    assign bad_issue = issue_fire & ~issue_ready;
    assign orphan    = res_valid & (inflight == '0);
    assign drop      = res_valid & full & ~m_ready;

    // Outstanding-op counter; an uncredited return saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue_ok, ret_ok})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Sticky protocol-violation flag.
    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if (drop | bad_issue | orphan) err <= 1'b1;
    end

    // The credit bound holds whenever the protocol is obeyed; an uncredited
    // return coinciding with a legal issue can exceed it, but that also
    // raises err in the same cycle.
    assert property (@(posedge clk) disable iff (rst) (err || credit_sum <= DEPTH_W))
        else $error("addsub_result_buffer %0d: occupancy+inflight exceeds DEPTH", INSTANCE_ID);

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Directed bench: buffer behind a 4-stage add/sub pipeline model.
module tb_addsub_result_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       adder_rst;
    logic       issue_fire;
    logic       issue_ready;
    logic [7:0] a, b;
    logic       op;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_carry;
    logic       frc_valid;
    logic [7:0] frc_data;
    logic       frc_carry;
    logic       m_valid, m_ready, m_carry, err;
    logic [7:0] m_data;
    logic [2:0] occupancy, inflight;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Adder model: result computed at launch, valid after 4 stages.
    logic [4:1] vld_pipe;
    logic [8:0] res_pipe [1:4];
    always @(posedge clk) begin
        if (adder_rst) vld_pipe <= '0;
        else           vld_pipe <= {vld_pipe[3:1], issue_fire};
        res_pipe[1] <= {1'b0, a} + {1'b0, (op ? ~b : b)} + {8'd0, op};
        for (int s = 2; s <= 4; s++) res_pipe[s] <= res_pipe[s-1];
    end

    assign res_valid = vld_pipe[4] | frc_valid;
    assign res_data  = frc_valid ? frc_data  : res_pipe[4][7:0];
    assign res_carry = frc_valid ? frc_carry : res_pipe[4][8];

    addsub_result_buffer #(
        .DATAWIDTH   (8),
        .DEPTH       (4),
        .INSTANCE_ID (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_fire  (issue_fire),
        .issue_ready (issue_ready),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_carry   (res_carry),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_carry     (m_carry),
        .occupancy   (occupancy),
        .inflight    (inflight),
        .err         (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic o);
        issue_fire = 1'b1; a = x; b = y; op = o;
        tick();
        issue_fire = 1'b0;
    endtask

    task automatic reset_all();
        rst = 1'b1; adder_rst = 1'b1;
        tick();
        rst = 1'b0; adder_rst = 1'b0;
    endtask

    // Four results 0x01..0x04 (carry 0), FIFO left full with no credits out.
    task automatic fill4();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) issue(8'(i), 8'h00, 1'b0);
        repeat (4) tick();
    endtask

    // Drain expectations: four exhaustion results then the four drain ops.
    logic [7:0] exp_d [0:7];
    logic       exp_c [0:7];
    logic [7:0] dr_a  [0:3];
    logic [7:0] dr_b  [0:3];
    logic       dr_op [0:3];

    initial begin
        int got, di, acc;
        exp_d = '{8'h11, 8'h22, 8'h10, 8'h02, 8'hFE, 8'h00, 8'h02, 8'hF0};
        exp_c = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dr_a  = '{8'hFF, 8'h80, 8'h01, 8'h10};
        dr_b  = '{8'h01, 8'h80, 8'h01, 8'h20};
        dr_op = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; adder_rst = 1'b1; issue_fire = 1'b0; a = '0; b = '0; op = 1'b0;
        m_ready = 1'b0; frc_valid = 1'b0; frc_data = '0; frc_carry = 1'b0;
        tick(); tick();
        check("rst_occupancy", 32'(occupancy), 0);
        check("rst_inflight", 32'(inflight), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_issue_ready", 32'(issue_ready), 1);
        rst = 1'b0; adder_rst = 1'b0;

        // Basic path: 0x35+0x12.
        m_ready = 1'b1;
        issue(8'h35, 8'h12, 1'b0);
        check("basic_inflight_1", 32'(inflight), 1);
        repeat (3) tick();
        check("basic_no_early_valid", 32'(m_valid), 0);
        tick();
        check("basic_m_valid", 32'(m_valid), 1);
        check("basic_m_data", 32'(m_data), 32'h47);
        check("basic_m_carry", 32'(m_carry), 0);
        check("basic_inflight_0", 32'(inflight), 0);
        tick();
        check("basic_popped", 32'(m_valid), 0);

        // Credit exhaustion with consumer stalled.
        m_ready = 1'b0;
        issue(8'h10, 8'h01, 1'b0);
        issue(8'h20, 8'h02, 1'b0);
        issue(8'hF0, 8'h20, 1'b0);
        issue(8'h05, 8'h03, 1'b1);
        check("exh_issue_ready_0", 32'(issue_ready), 0);
        check("exh_inflight_4", 32'(inflight), 4);
        acc = 0;
        repeat (4) begin
            issue_fire = issue_ready;
            if (issue_fire) acc++;
            tick();
        end
        issue_fire = 1'b0;
        check("exh_no_extra_issue", 32'(acc), 0);
        check("exh_occupancy_4", 32'(occupancy), 4);
        check("exh_inflight_0", 32'(inflight), 0);
        check("exh_err", 32'(err), 0);

        // Drain in order, re-issuing as credits free up.
        m_ready = 1'b1;
        got = 0; di = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (m_valid) begin
                check("drain_data", 32'(m_data), 32'(exp_d[got]));
                check("drain_carry", 32'(m_carry), 32'(exp_c[got]));
                got++;
            end
            if (issue_ready && di < 4) begin
                issue_fire = 1'b1; a = dr_a[di]; b = dr_b[di]; op = dr_op[di]; di++;
            end else begin
                issue_fire = 1'b0;
            end
            tick();
            if (cyc == 0) check("credit_after_first_pop", 32'(issue_ready), 1);
        end
        issue_fire = 1'b0;
        check("drain_count", 32'(got), 8);
        check("drain_occupancy", 32'(occupancy), 0);
        check("drain_inflight", 32'(inflight), 0);
        check("drain_err", 32'(err), 0);

        // Issue and return in the same cycle.
        issue(8'h01, 8'h02, 1'b0);
        repeat (3) tick();
        check("same_cyc_pre_inflight", 32'(inflight), 1);
        issue(8'h07, 8'h08, 1'b0);
        check("same_cyc_inflight", 32'(inflight), 1);
        check("same_cyc_head", 32'(m_data), 32'h03);
        for (int k = 0; k < 10 && !(m_valid && m_data == 8'h0F); k++) tick();
        check("same_cyc_second", 32'(m_data), 32'h0F);
        tick();
        check("same_cyc_empty", 32'(occupancy), 0);

        // Forced push while full: with a pop it lands, without one it drops.
        fill4();
        frc_valid = 1'b1; frc_data = 8'h5A; frc_carry = 1'b1; m_ready = 1'b1;
        tick();
        check("full_pushpop_occ", 32'(occupancy), 4);
        check("full_pushpop_head", 32'(m_data), 32'h02);
        check("full_pushpop_orphan_err", 32'(err), 1);
        frc_data = 8'hA5; frc_carry = 1'b0; m_ready = 1'b0;
        tick();
        frc_valid = 1'b0;
        check("full_drop_occ", 32'(occupancy), 4);
        m_ready = 1'b1;
        repeat (3) tick();
        check("full_kept_data", 32'(m_data), 32'h5A);
        check("full_kept_carry", 32'(m_carry), 1);
        check("full_kept_occ", 32'(occupancy), 1);
        tick();
        check("full_dropped_gone", 32'(m_valid), 0);

        reset_all();
        check("reset_clears_err", 32'(err), 0);
        check("reset_issue_ready", 32'(issue_ready), 1);

        // Illegal issue without credit.
        fill4();
        check("viol_pre_ready", 32'(issue_ready), 0);
        check("viol_pre_err", 32'(err), 0);
        issue(8'h09, 8'h09, 1'b0);
        check("viol_issue_err", 32'(err), 1);
        check("viol_issue_inflight", 32'(inflight), 0);

        // Uncredited return after reset: flagged but stored.
        reset_all();
        frc_valid = 1'b1; frc_data = 8'h33; frc_carry = 1'b0; m_ready = 1'b0;
        tick();
        frc_valid = 1'b0;
        check("orphan_err", 32'(err), 1);
        check("orphan_occ", 32'(occupancy), 1);
        check("orphan_data", 32'(m_data), 32'h33);
        check("orphan_inflight", 32'(inflight), 0);

        // Reset mid-flight, adder left running.
        reset_all();
        for (int i = 1; i <= 4; i++) issue(8'(i), 8'h00, 1'b0);
        repeat (2) tick();
        check("mid_pre_occ", 32'(occupancy), 2);
        check("mid_pre_inflight", 32'(inflight), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_occ", 32'(occupancy), 0);
        check("mid_inflight", 32'(inflight), 0);
        check("mid_m_valid", 32'(m_valid), 0);
        check("mid_err_clear", 32'(err), 0);
        tick();
        check("mid_stale_err", 32'(err), 1);
        check("mid_stale_stored", 32'(occupancy), 1);

        // Same, with the adder reset alongside.
        reset_all();
        for (int i = 1; i <= 4; i++) issue(8'(i), 8'h00, 1'b0);
        repeat (2) tick();
        reset_all();
        check("joint_occ", 32'(occupancy), 0);
        check("joint_inflight", 32'(inflight), 0);
        repeat (6) tick();
        check("joint_err", 32'(err), 0);
        check("joint_m_valid", 32'(m_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
